// File: rtl/dram_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester DRAM port arbiter.
package dram_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_BITS           = 24;
  localparam int unsigned XLEN                    = 32;
  localparam int unsigned DRAM_ARB_TIMEOUT_CYCLES = 1023;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and DRAM-side signals of the arbiter. The slave modport is the arbiter's
// view; the master modport is the view of the requesters plus the DRAM model.
interface dram_port_arbiter_if #(
  parameter int unsigned ADDR_BITS = dram_port_arbiter_pkg::MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS = dram_port_arbiter_pkg::XLEN
);

  logic [1:0]                  rq_read_en;
  logic [1:0]                  rq_write_en;
  logic [1:0][ADDR_BITS-1:0]   rq_addr;
  logic [1:0][DATA_BITS/8-1:0] rq_byte_enable;
  logic [1:0][DATA_BITS-1:0]   rq_write_data;
  logic [1:0]                  rq_ack;
  logic [1:0][DATA_BITS-1:0]   rq_read_data;
  logic [1:0]                  rq_error;

  logic                        dram_ack;
  logic [DATA_BITS-1:0]        dram_mem_read_data;
  logic [ADDR_BITS-1:0]        dram_mem_addr;
  logic [DATA_BITS/8-1:0]      dram_mem_byte_enable;
  logic [DATA_BITS-1:0]        dram_mem_write_data;
  logic                        dram_mem_read_en;
  logic                        dram_mem_write_en;

  logic                        busy;

  modport slave (
    input  rq_read_en, rq_write_en, rq_addr, rq_byte_enable, rq_write_data,
    output rq_ack, rq_read_data, rq_error,
    input  dram_ack, dram_mem_read_data,
    output dram_mem_addr, dram_mem_byte_enable, dram_mem_write_data,
    output dram_mem_read_en, dram_mem_write_en,
    output busy
  );

  modport master (
    output rq_read_en, rq_write_en, rq_addr, rq_byte_enable, rq_write_data,
    input  rq_ack, rq_read_data, rq_error,
    output dram_ack, dram_mem_read_data,
    input  dram_mem_addr, dram_mem_byte_enable, dram_mem_write_data,
    input  dram_mem_read_en, dram_mem_write_en,
    input  busy
  );

endinterface

// File: rtl/dram_arb_rr_pick.sv
// Combinational two-way round-robin pick: a tie goes to the requester not served last.
module dram_arb_rr_pick (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req_valid;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between two requesters, one registered transaction at a time.
// Optional WAIT watchdog is enabled with `define DRAM_ARB_TIMEOUT_EN.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = MEM_ADDR_BITS,
  parameter int unsigned DATA_BITS      = XLEN,
  parameter int unsigned TIMEOUT_CYCLES = DRAM_ARB_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_reset,
  dram_port_arbiter_if.slave bus
);

  localparam int unsigned BE_BITS = DATA_BITS / 8;

  arb_state_e                state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      grant_q, grant_d;
  logic [1:0]                req_valid;
  logic                      grant_valid, grant_idx;
  logic                      timeout;

  logic [ADDR_BITS-1:0]      addr_q, addr_d;
  logic [BE_BITS-1:0]        be_q, be_d;
  logic [DATA_BITS-1:0]      wdata_q, wdata_d;
  logic                      rd_en_q, rd_en_d;
  logic                      wr_en_q, wr_en_d;
  logic [1:0]                ack_q, ack_d;
  logic [1:0]                err_q, err_d;
  logic [1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic                      busy_q, busy_d;

  assign req_valid = bus.rq_read_en | bus.rq_write_en;

  dram_arb_rr_pick u_pick (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;

  // Counter holds the number of cycles elapsed since the command pulse (0 during ISSUE).
  assign cnt_inc = cnt_q + CNT_BITS'(1);
  assign timeout = (state_q == StWait) && (cnt_inc == CNT_BITS'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (sync_reset || state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StIssue || state_q == StWait) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cycles;

  assign timeout               = 1'b0;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          grant_d = grant_idx;
          addr_d  = bus.rq_addr[grant_idx];
          be_d    = bus.rq_byte_enable[grant_idx];
          wdata_d = bus.rq_write_data[grant_idx];
          // Write takes precedence when a requester raises both levels.
          wr_en_d = bus.rq_write_en[grant_idx];
          rd_en_d = ~bus.rq_write_en[grant_idx];
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.dram_ack) begin
          rdata_d[grant_q] = bus.dram_mem_read_data;
          ack_d[grant_q]   = 1'b1;
          last_grant_d     = grant_q;
          state_d          = StDone;
        end else if (timeout) begin
          rdata_d[grant_q] = '0;
          ack_d[grant_q]   = 1'b1;
          err_d[grant_q]   = 1'b1;
          last_grant_d     = grant_q;
          state_d          = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);

    if (sync_reset) begin
      state_d      = StIdle;
      last_grant_d = 1'b1;
      grant_d      = 1'b0;
      addr_d       = '0;
      be_d         = '0;
      wdata_d      = '0;
      rd_en_d      = 1'b0;
      wr_en_d      = 1'b0;
      ack_d        = '0;
      err_d        = '0;
      rdata_d      = '0;
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dram_mem_addr        = addr_q;
  assign bus.dram_mem_byte_enable = be_q;
  assign bus.dram_mem_write_data  = wdata_q;
  assign bus.dram_mem_read_en     = rd_en_q;
  assign bus.dram_mem_write_en    = wr_en_q;
  assign bus.rq_ack               = ack_q;
  assign bus.rq_error             = err_q;
  assign bus.rq_read_data         = rdata_q;
  assign bus.busy                 = busy_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomized self-checking bench for dram_port_arbiter against a transaction-level model.
module tb_dram_port_arbiter;
  import dram_port_arbiter_pkg::*;

  localparam int unsigned AW = MEM_ADDR_BITS;
  localparam int unsigned DW = XLEN;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 16;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic sync_reset = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model state: who was served last and what each requester should currently read back.
  logic          last_grant_m;
  logic [DW-1:0] exp_rdata [2];
  logic          req_rd    [2];
  logic          req_wr    [2];
  logic [AW-1:0] req_addr  [2];
  logic [BW-1:0] req_be    [2];
  logic [DW-1:0] req_wd    [2];
  int            dir_lat     = -1;
  bit            dir_data_en = 1'b0;
  logic [DW-1:0] dir_data    = '0;
  int            order [$];

  dram_port_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  dram_port_arbiter #(
    .ADDR_BITS      (AW),
    .DATA_BITS      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [1:0] pend, input logic lg);
    if (pend == 2'b11) return lg ? 0 : 1;
    return pend[0] ? 0 : 1;
  endfunction

  task automatic new_req(input int g);
    int kind;
    kind        = $urandom_range(0, 2);
    req_rd[g]   = (kind != 1);
    req_wr[g]   = (kind != 0);
    req_addr[g] = AW'($urandom);
    req_be[g]   = BW'($urandom);
    req_wd[g]   = $urandom;
  endtask

  task automatic drive_req(input int g, input bit on);
    bus.rq_read_en[g]     = on ? req_rd[g] : 1'b0;
    bus.rq_write_en[g]    = on ? req_wr[g] : 1'b0;
    bus.rq_addr[g]        = on ? req_addr[g] : '0;
    bus.rq_byte_enable[g] = on ? req_be[g] : '0;
    bus.rq_write_data[g]  = on ? req_wd[g] : '0;
  endtask

  task automatic clear_model();
    last_grant_m = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rq_ack"}, bus.rq_ack, 0);
    check_eq({tag, "_rq_error"}, bus.rq_error, 0);
    check_eq({tag, "_rq_read_data"}, bus.rq_read_data, 0);
    check_eq({tag, "_addr"}, bus.dram_mem_addr, 0);
    check_eq({tag, "_be"}, bus.dram_mem_byte_enable, 0);
    check_eq({tag, "_wdata"}, bus.dram_mem_write_data, 0);
    check_eq({tag, "_rd_en"}, bus.dram_mem_read_en, 0);
    check_eq({tag, "_wr_en"}, bus.dram_mem_write_en, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
  endtask

  // Serves every active requester; with sustain > 0 each acked requester re-requests until
  // that many transactions have been served. Starts and ends on an idle cycle.
  task automatic run_group(input logic [1:0] act, input int sustain, input bit rnd);
    logic [1:0]    pend;
    int            g, steps, lat, served;
    logic [DW-1:0] d;
    pend   = act;
    served = 0;
    for (int r = 0; r < 2; r++) begin
      if (act[r]) begin
        if (rnd) new_req(r);
        drive_req(r, 1'b1);
      end
    end
    while (pend != 2'b00) begin
      g     = pick(pend, last_grant_m);
      steps = 0;
      do begin
        step();
        steps++;
      end while (!(bus.dram_mem_read_en || bus.dram_mem_write_en) && steps < 8);
      check_eq("cmd_latency", steps, 1);
      if (!(bus.dram_mem_read_en || bus.dram_mem_write_en)) begin
        drive_req(0, 1'b0);
        drive_req(1, 1'b0);
        return;
      end
      check_eq("cmd_write_en", bus.dram_mem_write_en, req_wr[g]);
      check_eq("cmd_read_en", bus.dram_mem_read_en, !req_wr[g]);
      check_eq("cmd_addr", bus.dram_mem_addr, req_addr[g]);
      check_eq("cmd_be", bus.dram_mem_byte_enable, req_be[g]);
      check_eq("cmd_wdata", bus.dram_mem_write_data, req_wd[g]);
      check_eq("issue_busy", bus.busy, 1);
      lat = (dir_lat >= 0) ? dir_lat : $urandom_range(0, 3);
      d   = dir_data_en ? dir_data : $urandom;
      for (int i = 0; i <= lat; i++) begin
        step();
        check_eq("wait_no_pulse", {bus.dram_mem_read_en, bus.dram_mem_write_en}, 0);
        check_eq("wait_addr", bus.dram_mem_addr, req_addr[g]);
        check_eq("wait_be", bus.dram_mem_byte_enable, req_be[g]);
        check_eq("wait_wdata", bus.dram_mem_write_data, req_wd[g]);
        check_eq("wait_no_ack", bus.rq_ack, 0);
        check_eq("wait_busy", bus.busy, 1);
      end
      bus.dram_ack           = 1'b1;
      bus.dram_mem_read_data = d;
      step();
      bus.dram_ack           = 1'b0;
      bus.dram_mem_read_data = $urandom;
      exp_rdata[g] = d;
      last_grant_m = g[0];
      order.push_back(int'(bus.rq_ack[1]));
      check_eq("ack_vec", bus.rq_ack, 2'b01 << g);
      check_eq("ack_rdata_own", bus.rq_read_data[g], exp_rdata[g]);
      check_eq("ack_rdata_other", bus.rq_read_data[1-g], exp_rdata[1-g]);
      check_eq("ack_error", bus.rq_error, 0);
      check_eq("done_busy", bus.busy, 1);
      drive_req(g, 1'b0);
      pend[g] = 1'b0;
      served++;
      step();
      check_eq("idle_busy", bus.busy, 0);
      check_eq("idle_no_ack", bus.rq_ack, 0);
      check_eq("idle_rdata_hold", bus.rq_read_data[g], exp_rdata[g]);
      if (served + $countones(pend) < sustain) begin
        new_req(g);
        drive_req(g, 1'b1);
        pend[g] = 1'b1;
      end
    end
  endtask

  task automatic stale_ack();
    bus.dram_ack           = 1'b1;
    bus.dram_mem_read_data = $urandom;
    step();
    bus.dram_ack = 1'b0;
    check_eq("stale_no_ack", bus.rq_ack, 0);
    check_eq("stale_busy", bus.busy, 0);
    check_eq("stale_rdata0", bus.rq_read_data[0], exp_rdata[0]);
    check_eq("stale_rdata1", bus.rq_read_data[1], exp_rdata[1]);
  endtask

  task automatic mid_wait_reset(input bit use_sync);
    new_req(0);
    drive_req(0, 1'b1);
    step();
    check_eq("rst_cmd_pulse", bus.dram_mem_read_en | bus.dram_mem_write_en, 1);
    step();
    if (use_sync) begin
      sync_reset = 1'b1;
      step();
      sync_reset = 1'b0;
      check_reset_state("sync_rst");
    end else begin
      reset_n = 1'b0;
      #1;
      check_reset_state("async_rst_now");
      step();
      check_reset_state("async_rst");
    end
    drive_req(0, 1'b0);
    reset_n = 1'b1;
    clear_model();
    step();
    bus.dram_ack           = 1'b1;
    bus.dram_mem_read_data = $urandom;
    step();
    bus.dram_ack = 1'b0;
    check_eq("late_ack_none", bus.rq_ack, 0);
    check_eq("late_ack_busy", bus.busy, 0);
    check_eq("late_ack_rdata", bus.rq_read_data, 0);
    step();
    check_eq("late_ack_none2", bus.rq_ack, 0);
    run_group(2'b01, 0, 1'b1);
  endtask

  task automatic timeout_test();
    new_req(0);
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b0;
    drive_req(0, 1'b1);
    step();
    check_eq("to_cmd_pulse", bus.dram_mem_read_en, 1);
`ifdef DRAM_ARB_TIMEOUT_EN
    for (int i = 1; i <= int'(TO); i++) begin
      step();
      if (i < int'(TO)) check_eq("to_early_ack", bus.rq_ack, 0);
    end
    check_eq("to_ack", bus.rq_ack, 2'b01);
    check_eq("to_error", bus.rq_error, 2'b01);
    check_eq("to_rdata", bus.rq_read_data[0], 0);
    exp_rdata[0] = '0;
    last_grant_m = 1'b0;
    drive_req(0, 1'b0);
    step();
    check_eq("to_idle_busy", bus.busy, 0);
    check_eq("to_idle_error", bus.rq_error, 0);
`else
    for (int i = 0; i < 40; i++) begin
      step();
      check_eq("hang_busy", bus.busy, 1);
      check_eq("hang_no_ack", bus.rq_ack, 0);
    end
    reset_n = 1'b0;
    step();
    check_reset_state("hang_rst");
    drive_req(0, 1'b0);
    reset_n = 1'b1;
    clear_model();
    step();
`endif
  endtask

  initial begin
    bus.rq_read_en         = '0;
    bus.rq_write_en        = '0;
    bus.rq_addr            = '0;
    bus.rq_byte_enable     = '0;
    bus.rq_write_data      = '0;
    bus.dram_ack           = 1'b0;
    bus.dram_mem_read_data = '0;
    for (int r = 0; r < 2; r++) begin
      req_rd[r]   = 1'b0;
      req_wr[r]   = 1'b0;
      req_addr[r] = '0;
      req_be[r]   = '0;
      req_wd[r]   = '0;
    end
    clear_model();
    repeat (3) step();
    check_reset_state("por");
    reset_n = 1'b1;
    step();

    // Directed single read from requester 0.
    req_rd[0]   = 1'b1;
    req_wr[0]   = 1'b0;
    req_addr[0] = AW'(32'h1234);
    req_be[0]   = '1;
    req_wd[0]   = '0;
    dir_lat     = 2;
    dir_data_en = 1'b1;
    dir_data    = 32'hDEAD_BEEF;
    run_group(2'b01, 0, 1'b0);
    check_eq("single_rdata", bus.rq_read_data[0], 32'hDEAD_BEEF);
    dir_lat     = -1;
    dir_data_en = 1'b0;

    // Fresh reset, then sustained contention over eight transactions.
    reset_n = 1'b0;
    step();
    check_reset_state("rst2");
    reset_n = 1'b1;
    clear_model();
    step();
    order.delete();
    run_group(2'b11, 8, 1'b1);
    check_eq("alt_count", order.size(), 8);
    foreach (order[i]) check_eq("alt_order", order[i], i % 2);

    // Directed write from requester 1 with partial lanes.
    req_rd[1]   = 1'b0;
    req_wr[1]   = 1'b1;
    req_addr[1] = AW'($urandom);
    req_be[1]   = BW'(4'b0011);
    req_wd[1]   = 32'hA5A5_A5A5;
    run_group(2'b10, 0, 1'b0);

    repeat (30) begin
      run_group(2'($urandom_range(1, 3)), $urandom_range(0, 5), 1'b1);
      if ($urandom_range(0, 3) == 0) stale_ack();
    end

    mid_wait_reset(1'b0);
    mid_wait_reset(1'b1);
    timeout_test();
    run_group(2'b11, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter that shares the single external DRAM port of the MCU between the core-side memory controller (requester 0) and a secondary master such as an OCD/DMA engine (requester 1). It grants one transaction at a time, round-robin. It sits between those masters and the top-level `dram_*` pins, and it registers command and response paths so DRAM timing stays decoupled from both masters.

## Interface
Parameters:
- `ADDR_BITS`, default `MEM_ADDR_BITS`: DRAM word address width.
- `DATA_BITS`, default `XLEN`: data width. The byte-enable width is `DATA_BITS/8`.
- `TIMEOUT_CYCLES`, default 1023: watchdog limit. Used only when the configuration macro is defined.

Ports (`n` is 0 or 1):
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sync_reset` in 1: synchronous reset, active high. Same effect as `reset_n`.
- `rq_read_en[n]` in 1: read request level. Held high until `rq_ack[n]`.
- `rq_write_en[n]` in 1: write request level. Held high until `rq_ack[n]`.
- `rq_addr[n]` in ADDR_BITS: request address. Stable while the request is high.
- `rq_byte_enable[n]` in DATA_BITS/8: write byte lanes.
- `rq_write_data[n]` in DATA_BITS: write data.
- `rq_ack[n]` out 1: one-cycle completion pulse.
- `rq_read_data[n]` out DATA_BITS: read data. Valid in the `rq_ack[n]` cycle and held until the next ack to the same requester.
- `rq_error[n]` out 1: timeout flag. Valid with `rq_ack[n]`.
- `dram_ack` in 1: DRAM completion pulse.
- `dram_mem_read_data` in DATA_BITS: DRAM read data. Valid with `dram_ack`.
- `dram_mem_addr` out ADDR_BITS: DRAM address.
- `dram_mem_byte_enable` out DATA_BITS/8: DRAM byte lanes.
- `dram_mem_write_data` out DATA_BITS: DRAM write data.
- `dram_mem_read_en` out 1: one-cycle read command pulse.
- `dram_mem_write_en` out 1: one-cycle write command pulse.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Arbitration: if exactly one requester is active, grant it. If both are active, grant the requester that is not `last_grant`.
  - On grant: latch the requester's addr, byte_enable, write_data and direction into the `dram_*` output registers, then go to ISSUE.
- **ISSUE**
  - Drive `dram_mem_read_en` or `dram_mem_write_en` high for exactly this cycle, then go to WAIT.
  - `dram_mem_addr`, `dram_mem_byte_enable` and `dram_mem_write_data` stay stable from ISSUE through the end of WAIT.
- **WAIT**
  - On `dram_ack`: capture `dram_mem_read_data` into `rq_read_data[g]`, pulse `rq_ack[g]` in the next cycle, set `last_grant <= g`, go to DONE.
- **DONE**
  - One cycle with no arbitration, so the acked requester can drop its request.
  - Then go to IDLE.

Request rules:
- If a requester asserts both read and write, the write wins and is treated as a write.
- A request withdrawn before its ack is a protocol violation; the behaviour is undefined.
- A `dram_ack` seen outside WAIT is ignored. This includes a stale ack after a reset.

Reset (`reset_n` low or `sync_reset` high):
- FSM returns to IDLE and `last_grant` = 1, so requester 0 wins the first tie.
- All outputs reset to 0: `rq_ack`, `rq_error`, `rq_read_data`, all `dram_*` outputs, `busy`.
- A DRAM transaction in flight at reset is abandoned and never acked.

## Timing
- Request high at edge N (FSM in IDLE) -> `dram_*_en` pulse in cycle N+1.
- `dram_ack` in cycle K -> `rq_ack` in cycle K+1 -> FSM back in IDLE at K+2.
- Best-case back-to-back issue spacing: `dram_ack` at K, next command pulse at K+3.
- Worst-case wait for a requester under contention: one full transaction of the other requester.
- `busy` is registered and goes high in the cycle after the grant.

## Configuration
Macro: `DRAM_ARB_TIMEOUT_EN`.

With the macro defined:
- A 10-bit counter (sized as `$clog2(TIMEOUT_CYCLES+1)`) clears in ISSUE and increments in WAIT.
- If it reaches `TIMEOUT_CYCLES` without `dram_ack`, the arbiter pulses `rq_ack[g]` together with `rq_error[g]`, sets `rq_read_data[g]` to 0, and goes to DONE.

Without the macro:
- There is no counter. WAIT blocks indefinitely until `dram_ack`.
- `rq_error` is tied to 0.

## Structure
- The FSM state encodings (2-bit, IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the default `TIMEOUT_CYCLES` go in `common.vh` alongside `MEM_ADDR_BITS` and `XLEN`.
- One sub-module, `dram_arb_rr_pick`: purely combinational. Inputs are the two request-valid bits and `last_grant`. Outputs are `grant_valid` and `grant_idx`.

## Test plan
- **Single read:** req0 reads addr 0x1234; DRAM acks 3 cycles after the pulse with 0xDEADBEEF.
  - Required: one `dram_mem_read_en` pulse carrying addr 0x1234; `rq_ack[0]` one cycle after `dram_ack`; `rq_read_data[0]` = 0xDEADBEEF; `rq_ack[1]` stays 0.
- **Simultaneous requests after reset:** both requesters assert in the same cycle.
  - Required: req0 served first, then req1. Sustained contention strictly alternates 0,1,0,1 over 8 transactions.
- **Write with byte lanes:** req1 writes 0xA5A5A5A5 with byte_enable 4'b0011.
  - Required: `dram_mem_write_data` = 0xA5A5A5A5 and `dram_mem_byte_enable` = 4'b0011, both stable from ISSUE until `dram_ack`; exactly one write pulse.
- **Reset mid-WAIT:** assert `reset_n` low during WAIT, release, then deliver a late `dram_ack`.
  - Required: no `rq_ack`; all outputs read 0; a subsequent req0 is granted normally.
- **Timeout (`DRAM_ARB_TIMEOUT_EN` defined, TIMEOUT_CYCLES = 16):** never assert `dram_ack`.
  - Required: `rq_ack[0]` and `rq_error[0]` pulse together 16 cycles after ISSUE; `rq_read_data[0]` = 0.
  - Same stimulus without the macro: FSM stays in WAIT and `busy` stays 1.
